move_and_merge_tiles: RTL and testbench

- 2048-game move engine: takes a 4x4 board snapshot and a one-hot direction, slides all tiles toward that edge, merges equal neighbours, and reports the resulting board and score gain.
- Sits between the game FSM, which supplies the board and start strobe, and the board register/score accumulator.
- Merge logic is combinational; results are registered with 1-cycle latency.

---
 rtl/move_and_merge_tiles.sv | 169 ++++++++++++++++
 tb/tb_move_and_merge_tiles.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/move_and_merge_tiles.sv
// move_and_merge_tiles
//   2048-game move engine. Slides and merges a 4x4 board toward the edge
//   selected by a one-hot direction and registers the new board and score gain
//   one cycle after a start strobe.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   start        sample direction/board_in on this edge
//   direction    one-hot: 0001 up, 0010 down, 0100 left, 1000 right
//   board_in     [0:15] tiles, index 4*row+col, row 0 top, col 0 left
//   board_out    registered result board, same indexing
//   score_update registered sum of tiles created by merges in the last move
//   moved        (MERGE_MOVED_FLAG_EN only) result differs from board_in
//   done         one-cycle pulse when board_out/score_update were updated
//
// Optional feature macro: MERGE_MOVED_FLAG_EN adds the registered moved flag.
module move_and_merge_tiles #(
    parameter int unsigned TILE_W  = 12,
    parameter int unsigned SCORE_W = 20
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [3:0]          direction,
    input  logic [TILE_W-1:0]   board_in [0:15],
    output logic [TILE_W-1:0]   board_out [0:15],
    output logic [SCORE_W-1:0]  score_update,
`ifdef MERGE_MOVED_FLAG_EN
    output logic                moved,
`endif
    output logic                done
);

    localparam logic [TILE_W-1:0] MERGE_LIMIT = TILE_W'(2048);

    typedef logic [3:0][TILE_W-1:0] line_t;

    // Board cell holding position p (0 = destination edge) of line l.
    function automatic int unsigned cell_idx(input logic [3:0] dir,
                                             input int unsigned l,
                                             input int unsigned p);
        case (dir)
            4'b0001: cell_idx = 4 * p + l;
            4'b0010: cell_idx = 4 * (3 - p) + l;
            4'b1000: cell_idx = 4 * l + (3 - p);
            default: cell_idx = 4 * l + p;
        endcase
    endfunction

    // Compact, merge each pair once scanning from the edge, and re-compact.
    // The compacted copy carries a fifth always-empty slot so the pair test
    // at the last position never needs a bounds guard.
    function automatic line_t merge_line(input line_t in,
                                         output logic [SCORE_W-1:0] gain);
        logic [4:0][TILE_W-1:0] c;
        line_t                  o;
        logic [2:0]             n;
        logic [2:0]             m;
        logic                   skip;
        c    = '0;
        o    = '0;
        n    = '0;
        m    = '0;
        skip = 1'b0;
        gain = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (in[i] != '0) begin
                c[n] = in[i];
                n    = n + 3'd1;
            end
        end
        for (int unsigned k = 0; k < 4; k++) begin
            if (skip) begin
                skip = 1'b0;
            end else if (c[k] != '0 && c[k] == c[k+1] && c[k] < MERGE_LIMIT) begin
                o[m[1:0]] = {c[k][TILE_W-2:0], 1'b0};
                gain      = gain + SCORE_W'({c[k], 1'b0});
                m         = m + 3'd1;
                skip      = 1'b1;
            end else if (c[k] != '0) begin
                o[m[1:0]] = c[k];
                m         = m + 3'd1;
            end
        end
        return o;
    endfunction

    logic [TILE_W-1:0]  board_q [0:15];
    logic [TILE_W-1:0]  board_d [0:15];
    logic [TILE_W-1:0]  result  [0:15];
    logic [SCORE_W-1:0] score_q, score_d;
    logic [SCORE_W-1:0] gain_total;
    logic [SCORE_W-1:0] line_gain;
    logic               done_q, done_d;
    line_t              line_in, line_out;
    logic               changed;
`ifdef MERGE_MOVED_FLAG_EN
    logic               moved_q, moved_d;
`endif

    always_comb begin
        result     = board_in;
        gain_total = '0;
        line_in    = '0;
        line_out   = '0;
        line_gain  = '0;
        changed    = 1'b0;
        // Invalid directions leave result as a straight copy of board_in.
        if ($onehot(direction)) begin
            for (int unsigned l = 0; l < 4; l++) begin
                for (int unsigned p = 0; p < 4; p++) begin
                    line_in[p] = board_in[cell_idx(direction, l, p)];
                end
                line_out   = merge_line(line_in, line_gain);
                gain_total = gain_total + line_gain;
                for (int unsigned p = 0; p < 4; p++) begin
                    result[cell_idx(direction, l, p)] = line_out[p];
                end
            end
        end
        for (int unsigned i = 0; i < 16; i++) begin
            if (result[i] != board_in[i]) begin
                changed = 1'b1;
            end
        end

        board_d = board_q;
        score_d = score_q;
        done_d  = 1'b0;
`ifdef MERGE_MOVED_FLAG_EN
        moved_d = moved_q;
`endif
        if (start) begin
            board_d = result;
            score_d = gain_total;
            done_d  = 1'b1;
`ifdef MERGE_MOVED_FLAG_EN
            moved_d = changed;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            board_q <= '{default: '0};
            score_q <= '0;
            done_q  <= 1'b0;
`ifdef MERGE_MOVED_FLAG_EN
            moved_q <= 1'b0;
`endif
        end else begin
            board_q <= board_d;
            score_q <= score_d;
            done_q  <= done_d;
`ifdef MERGE_MOVED_FLAG_EN
            moved_q <= moved_d;
`endif
        end
    end

    assign board_out    = board_q;
    assign score_update = score_q;
    assign done         = done_q;
`ifdef MERGE_MOVED_FLAG_EN
    assign moved        = moved_q;
`endif

endmodule

// File: tb/tb_move_and_merge_tiles.sv
// Testbench for move_and_merge_tiles: directed cases with hand-computed
// expectations plus randomized moves checked against a queue-based model.
module tb_move_and_merge_tiles;

    typedef logic [11:0] tile_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic [3:0]  direction;
    tile_t       board_in  [0:15];
    tile_t       board_out [0:15];
    logic [19:0] score_update;
    logic        done;
`ifdef MERGE_MOVED_FLAG_EN
    logic        moved;
`endif

    int unsigned checks = 0;
    int unsigned errors = 0;

    move_and_merge_tiles #(.TILE_W(12), .SCORE_W(20)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .direction    (direction),
        .board_in     (board_in),
        .board_out    (board_out),
        .score_update (score_update),
`ifdef MERGE_MOVED_FLAG_EN
        .moved        (moved),
`endif
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [191:0] pack(input tile_t b [0:15]);
        logic [191:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) r[(15 - i) * 12 +: 12] = b[i];
        return r;
    endfunction

    // Reference: walk each line from the destination edge, queue the
    // non-empty tiles, then pop pairs off the queue front.
    task automatic ref_move(input tile_t b [0:15], input logic [3:0] d,
                            output tile_t r [0:15], output int unsigned sc);
        tile_t q[$];
        tile_t o[$];
        tile_t a;
        int    row, col;
        r  = b;
        sc = 0;
        if (!(d == 4'b0001 || d == 4'b0010 || d == 4'b0100 || d == 4'b1000)) return;
        for (int l = 0; l < 4; l++) begin
            q.delete();
            o.delete();
            for (int p = 0; p < 4; p++) begin
                row = (d == 4'b0001) ? p : (d == 4'b0010) ? 3 - p : l;
                col = (d == 4'b0100) ? p : (d == 4'b1000) ? 3 - p : l;
                if (b[4 * row + col] != 0) q.push_back(b[4 * row + col]);
            end
            while (q.size() > 0) begin
                a = q.pop_front();
                if (q.size() > 0 && q[0] == a && a < 2048) begin
                    void'(q.pop_front());
                    o.push_back(a * 2);
                    sc += 2 * a;
                end else begin
                    o.push_back(a);
                end
            end
            while (o.size() < 4) o.push_back(0);
            for (int p = 0; p < 4; p++) begin
                row = (d == 4'b0001) ? p : (d == 4'b0010) ? 3 - p : l;
                col = (d == 4'b0100) ? p : (d == 4'b1000) ? 3 - p : l;
                r[4 * row + col] = o[p];
            end
        end
    endtask

    // Directed move with hand-derived expected board and score.
    task automatic expect_move(input string tag, input tile_t b [0:15], input logic [3:0] d,
                               input tile_t eb [0:15], input int unsigned es);
        board_in  = b;
        direction = d;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check({tag, "_board"}, pack(board_out), pack(eb));
        check({tag, "_score"}, 192'(score_update), 192'(es));
        check({tag, "_done"}, 192'(done), 192'(1));
`ifdef MERGE_MOVED_FLAG_EN
        check({tag, "_moved"}, 192'(moved), 192'(pack(eb) != pack(b)));
`endif
        @(posedge clk);
        #1;
        check({tag, "_done_drop"}, 192'(done), 192'(0));
        check({tag, "_hold"}, pack(board_out), pack(eb));
    endtask

    tile_t       zero_b [0:15];
    tile_t       b_up   [0:15];
    tile_t       e_up   [0:15];
    tile_t       b_lr   [0:15];
    tile_t       e_left [0:15];
    tile_t       e_rght [0:15];
    tile_t       b_dn   [0:15];
    tile_t       e_dn   [0:15];
    tile_t       b_max  [0:15];
    tile_t       e_max  [0:15];
    tile_t       b_stk  [0:15];
    tile_t       rb     [0:15];
    tile_t       eb     [0:15];
    logic [3:0]  dirs   [0:7];
    logic [191:0] last_b;
    logic [191:0] last_s;
    logic         last_m;
    int unsigned  es;
    logic         st;
    int unsigned  r;

    initial begin
        zero_b = '{default: 12'd0};
        b_up   = '{2,2,4,4, 2,2,4,4, 0,0,0,0, 0,0,0,0};
        e_up   = '{4,4,8,8, 0,0,0,0, 0,0,0,0, 0,0,0,0};
        b_lr   = '{2,2,2,2, 2,2,2,0, 4,0,4,8, 0,0,0,2};
        e_left = '{4,4,0,0, 4,2,0,0, 8,8,0,0, 2,0,0,0};
        e_rght = '{0,0,4,4, 0,0,2,4, 0,0,8,8, 0,0,0,2};
        b_dn   = '{2,0,0,0, 2,0,0,0, 4,0,0,0, 0,0,0,0};
        e_dn   = '{0,0,0,0, 0,0,0,0, 4,0,0,0, 4,0,0,0};
        b_max  = '{2048,2048,1024,1024, 0,0,0,0, 0,0,0,0, 0,0,0,0};
        e_max  = '{2048,2048,2048,0, 0,0,0,0, 0,0,0,0, 0,0,0,0};
        b_stk  = '{2,4,8,16, 0,0,0,0, 0,0,0,0, 0,0,0,0};
        dirs   = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0100, 4'b0000, 4'b0011};

        rst       = 1'b1;
        start     = 1'b0;
        direction = 4'b0000;
        board_in  = zero_b;
        @(posedge clk);
        #1;
        check("rst_board", pack(board_out), '0);
        check("rst_score", 192'(score_update), '0);
        check("rst_done", 192'(done), '0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("idle_board", pack(board_out), '0);
        check("idle_done", 192'(done), '0);

        expect_move("up", b_up, 4'b0001, e_up, 24);
        expect_move("left", b_lr, 4'b0100, e_left, 20);
        expect_move("right", b_lr, 4'b1000, e_rght, 20);
        expect_move("down", b_dn, 4'b0010, e_dn, 4);
        expect_move("max", b_max, 4'b0100, e_max, 2048);
        expect_move("dir0000", b_lr, 4'b0000, b_lr, 0);
        expect_move("dir0011", b_lr, 4'b0011, b_lr, 0);
        expect_move("stuck", b_stk, 4'b0100, b_stk, 0);

        // Back-to-back starts: two results on consecutive cycles.
        board_in  = b_lr;
        direction = 4'b0100;
        start     = 1'b1;
        @(posedge clk);
        #1;
        check("b2b_first", pack(board_out), pack(e_left));
        check("b2b_first_done", 192'(done), 192'(1));
        direction = 4'b1000;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("b2b_second", pack(board_out), pack(e_rght));
        check("b2b_second_done", 192'(done), 192'(1));
        check("b2b_second_score", 192'(score_update), 192'(20));

        // Asynchronous reset mid-cycle while a start is pending.
        @(negedge clk);
        board_in  = b_up;
        direction = 4'b0001;
        start     = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check("arst_board", pack(board_out), '0);
        check("arst_score", 192'(score_update), '0);
        check("arst_done", 192'(done), '0);
        @(posedge clk);
        #1;
        check("arst_discard", pack(board_out), '0);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("arst_after_board", pack(board_out), '0);
        check("arst_after_done", 192'(done), '0);

        // Randomized moves with random start gaps; held outputs are tracked.
        last_b = '0;
        last_s = '0;
        last_m = 1'b0;
        for (int it = 0; it < 300; it++) begin
            for (int i = 0; i < 16; i++) begin
                r = $urandom_range(0, 15);
                rb[i] = (r == 0 || r > 11) ? 12'd0 : 12'(1 << r);
            end
            board_in  = rb;
            direction = dirs[$urandom_range(0, 7)];
            st        = ($urandom_range(0, 3) != 0);
            start     = st;
            if (st) begin
                ref_move(rb, direction, eb, es);
                last_b = pack(eb);
                last_s = 192'(es);
                last_m = (pack(eb) != pack(rb));
            end
            @(posedge clk);
            #1;
            check("rand_board", pack(board_out), last_b);
            check("rand_score", 192'(score_update), last_s);
            check("rand_done", 192'(done), 192'(st));
`ifdef MERGE_MOVED_FLAG_EN
            check("rand_moved", 192'(moved), 192'(last_m));
`endif
        end
        start = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
